conv_seq_ctrl: RTL
==================

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32: image width and height in pixels (square frame).
REQ-002 SHALL have parameter KERNEL_SIZE, default 5: convolution window edge.
REQ-003 SHALL have parameter STRIDE, default 1: window step in both axes, at least 1.
REQ-004 SHALL have parameter CNT_BW, default 6: row/col counter width; must satisfy 2^CNT_BW > DATA_SIZE.
REQ-005 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port: i_start  in  1  frame start request, sampled only in IDLE.
REQ-008 SHALL have port: i_pix_valid  in  1  upstream pixel valid.
REQ-009 SHALL have port: o_pix_ready  out  1  pixel accept; a pixel is accepted on i_pix_valid && o_pix_ready.
REQ-010 SHALL have port: o_shift_en  out  1  line-buffer shift strobe, equal to pixel accept, combinational.
REQ-011 SHALL have port: o_win_valid  out  1  registered flag: a complete window is present in the datapath.
REQ-012 SHALL have port: i_out_ready  in  1  downstream accept for o_win_valid.
REQ-013 SHALL have ports: o_row and o_col  out  CNT_BW each  position of the next pixel to be accepted.
REQ-014 SHALL have port: o_out_cnt  out  16  windows handed off in the current frame.
REQ-015 SHALL have ports: o_busy  out  1  state != IDLE; o_done  out  1  one-cycle end-of-frame pulse.

Function
REQ-016 SHALL implement the FSM IDLE -> RUN -> FLUSH -> DONE -> IDLE.
REQ-017 IDLE SHALL go to RUN on i_start, clearing row, col and o_out_cnt; i_start in any other state SHALL be ignored.
REQ-018 o_pix_ready SHALL be 1 only in RUN and only when not (o_win_valid && !i_out_ready).
REQ-019 Each accept SHALL increment col; at col == DATA_SIZE-1, col SHALL wrap to 0 and row SHALL increment.
REQ-020 An accept at (row,col) with row >= KERNEL_SIZE-1, col >= KERNEL_SIZE-1, (row-KERNEL_SIZE+1)%STRIDE == 0 and (col-KERNEL_SIZE+1)%STRIDE == 0 SHALL set o_win_valid on the next cycle (latency 1).
REQ-021 o_win_valid SHALL hold until the cycle with i_out_ready high; that cycle SHALL clear it and increment o_out_cnt, unless a new qualifying accept in the same cycle sets it again.
REQ-022 Accepting (DATA_SIZE-1, DATA_SIZE-1) SHALL move RUN to FLUSH and return row and col to 0.
REQ-023 FLUSH SHALL go to DONE once o_win_valid is 0; DONE SHALL last one cycle with o_done=1, then go to IDLE.
REQ-024 A completed frame SHALL give o_out_cnt = ((DATA_SIZE-KERNEL_SIZE)/STRIDE+1)^2, held until the next i_start.
REQ-025 i_pix_valid outside RUN SHALL have no effect.

Reset
REQ-026 With rst_n low, all outputs SHALL read: state IDLE, o_pix_ready 0, o_shift_en 0, o_win_valid 0, o_row 0, o_col 0, o_out_cnt 0, o_busy 0, o_done 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame immediately, with no o_done pulse.

Configuration
REQ-028 With macro CONV_SEQ_ABORT_EN defined, the block SHALL have input port i_abort (1 bit); i_abort high in RUN or FLUSH SHALL force IDLE on the next edge, clear o_win_valid, row and col, keep o_out_cnt, and give no o_done.
REQ-029 Without CONV_SEQ_ABORT_EN, the i_abort port SHALL NOT exist and frames SHALL end only through DONE or reset.

Verification (DATA_SIZE=8, KERNEL_SIZE=3, STRIDE=2, CNT_BW=4)
REQ-030 Start, then 64 pixels back-to-back with i_out_ready=1 -> o_win_valid after accepts at (2,2),(2,4),(2,6),(4,2)...(6,6); o_out_cnt=9; one o_done pulse; o_busy low after it.
REQ-031 i_out_ready=0 when the (2,2) window appears -> o_pix_ready=0 and row/col frozen at (2,3) until i_out_ready=1; no window lost, final count 9.
REQ-032 i_out_ready held 0 after the last accept -> FSM stays in FLUSH; o_done fires 2 cycles after i_out_ready rises.
REQ-033 i_start pulsed during RUN at (3,1) -> no counter change; frame completes normally with count 9.
REQ-034 rst_n low for 1 cycle at (5,0) -> all outputs at reset values; next i_start starts from (0,0).
REQ-035 CONV_SEQ_ABORT_EN defined, i_abort at (4,5) -> IDLE next cycle, o_out_cnt=4, no o_done.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// Frame sequencer for a sliding-window convolution: counts pixels, flags windows, drains, pulses done.
// Optional `CONV_SEQ_ABORT_EN adds an i_abort input that drops the current frame.
module conv_seq_ctrl #(
  parameter int DATA_SIZE   = 32,
  parameter int KERNEL_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int CNT_BW      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
`ifdef CONV_SEQ_ABORT_EN
  input  logic              i_abort,
`endif
  input  logic              i_pix_valid,
  output logic              o_pix_ready,
  output logic              o_shift_en,
  output logic              o_win_valid,
  input  logic              i_out_ready,
  output logic [CNT_BW-1:0] o_row,
  output logic [CNT_BW-1:0] o_col,
  output logic [15:0]       o_out_cnt,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_state
);

  // Handshakes: a pixel moves when i_pix_valid && o_pix_ready; a window moves when o_win_valid && i_out_ready.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [CNT_BW-1:0] LAST = CNT_BW'(DATA_SIZE - 1);
  localparam logic [CNT_BW-1:0] KM1  = CNT_BW'(KERNEL_SIZE - 1);
  localparam logic [CNT_BW-1:0] STR  = CNT_BW'(STRIDE);

  state_t            state, state_nxt;
  logic [CNT_BW-1:0] row, col, row_nxt, col_nxt;
  logic              win_valid, win_nxt;
  logic [15:0]       out_cnt, cnt_nxt;
  logic              accept, qualify, abort;

`ifdef CONV_SEQ_ABORT_EN
  assign abort = i_abort && ((state == S_RUN) || (state == S_FLUSH));
`else
  assign abort = 1'b0;
`endif

  // Backpressure: stop taking pixels while a window is waiting on downstream.
  assign o_pix_ready = (state == S_RUN) && !(win_valid && !i_out_ready);
  assign accept      = i_pix_valid && o_pix_ready;
  assign qualify     = (row >= KM1) && (col >= KM1) &&
                       (((row - KM1) % STR) == '0) && (((col - KM1) % STR) == '0);

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    win_nxt   = win_valid;
    cnt_nxt   = out_cnt;
    if (win_valid && i_out_ready) begin
      win_nxt = 1'b0;
      cnt_nxt = out_cnt + 16'd1;
    end
    if (accept && qualify) win_nxt = 1'b1;
    if (accept) begin
      if (col == LAST) begin
        col_nxt = '0;
        row_nxt = (row == LAST) ? '0 : row + 1'b1;
      end else begin
        col_nxt = col + 1'b1;
      end
    end
    case (state)
      S_IDLE: if (i_start) begin
        state_nxt = S_RUN;
        row_nxt   = '0;
        col_nxt   = '0;
        cnt_nxt   = '0;
      end
      S_RUN:   if (accept && (row == LAST) && (col == LAST)) state_nxt = S_FLUSH;
      S_FLUSH: if (!win_valid) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // An abort drops any pending window without counting it.
    if (abort) begin
      state_nxt = S_IDLE;
      win_nxt   = 1'b0;
      row_nxt   = '0;
      col_nxt   = '0;
      cnt_nxt   = out_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      out_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      col       <= col_nxt;
      win_valid <= win_nxt;
      out_cnt   <= cnt_nxt;
    end
  end

  assign o_shift_en  = accept;
  assign o_win_valid = win_valid;
  assign o_row       = row;
  assign o_col       = col;
  assign o_out_cnt   = out_cnt;
  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);
  assign o_state     = state;

endmodule
